// File: rtl/mvb_word_collector_if.sv
// Drain stream from the MVB word collector to the frame/port logic.
// Master drives data/valid/last, slave returns ready.
interface mvb_word_collector_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mvb_word_collector.sv
// MVB word collector: buffers deserialized words, checks frame length and
// drains accepted frames. Optional check word via MVB_WORD_CHECKSUM_EN.
module mvb_word_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk_3M,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [4:0]           frame_len,
    input  logic [15:0]          word_in,
    input  logic                 word_valid,
    input  logic                 frame_end,
    mvb_word_collector_if.master dn,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'(DEPTH);

    state_t      state_q, state_d;
    logic [4:0]  len_q, len_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rd_nxt;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        ok_d, err_d;
    logic [1:0]  code_q, code_d;
    logic        busy_d;
    logic        wr_en;
    logic        len_good;
    logic [4:0]  lim;
`ifdef MVB_WORD_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] chk_q, chk_d;
`endif

    logic [15:0] mem [DEPTH];

    assign dn.out_data  = data_q;
    assign dn.out_valid = valid_q;
    assign dn.out_last  = last_q;
    assign err_code     = code_q;

`ifdef MVB_WORD_CHECKSUM_EN
    assign lim = len_q + 5'd1;
`else
    assign lim = len_q;
`endif

    assign rd_nxt   = rd_q + 1'b1;
    assign len_good = (frame_len != 5'd0) && (frame_len <= MAX_LEN);

    // Next-state and next-output decode for the collect/drain sequence
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        rd_d    = rd_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
`ifdef MVB_WORD_CHECKSUM_EN
        acc_d   = acc_q;
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (len_good) begin
                        len_d   = frame_len;
                        cnt_d   = 5'd0;
                        ovf_d   = 1'b0;
`ifdef MVB_WORD_CHECKSUM_EN
                        acc_d   = 16'h0000;
`endif
                        state_d = COLLECT;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b11;
                    end
                end
            end
            COLLECT: begin
                if (frame_start) begin
                    // abort counts as short; a bad new length wins the code
                    err_d = 1'b1;
                    if (len_good) begin
                        code_d  = 2'b01;
                        len_d   = frame_len;
                        cnt_d   = 5'd0;
                        ovf_d   = 1'b0;
`ifdef MVB_WORD_CHECKSUM_EN
                        acc_d   = 16'h0000;
`endif
                        state_d = COLLECT;
                    end else begin
                        code_d  = 2'b11;
                        state_d = IDLE;
                    end
                end else begin
                    if (word_valid) begin
                        if (cnt_q < lim) begin
`ifdef MVB_WORD_CHECKSUM_EN
                            if (cnt_q < len_q) begin
                                wr_en = 1'b1;
                                acc_d = acc_q ^ word_in;
                            end else begin
                                chk_d = word_in;
                            end
`else
                            wr_en = 1'b1;
`endif
                            cnt_d = cnt_q + 5'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (frame_end) begin
                        if (ovf_d) begin
                            err_d   = 1'b1;
                            code_d  = 2'b10;
                            state_d = IDLE;
                        end else if (cnt_d < lim) begin
                            err_d   = 1'b1;
                            code_d  = 2'b01;
                            state_d = IDLE;
`ifdef MVB_WORD_CHECKSUM_EN
                        end else if (chk_d != acc_d) begin
                            err_d   = 1'b1;
                            code_d  = 2'b11;
                            state_d = IDLE;
`endif
                        end else begin
                            ok_d    = 1'b1;
                            rd_d    = '0;
                            valid_d = 1'b1;
                            last_d  = (len_q == 5'd1);
                            // word 0 may be written on this very edge
                            data_d  = (wr_en && cnt_q == 5'd0) ? word_in : mem[0];
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (frame_start) begin
                    err_d  = 1'b1;
                    code_d = 2'b11;
                end
                if (valid_q && dn.out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        rd_d   = rd_nxt;
                        data_d = mem[rd_nxt];
                        last_d = (5'(rd_nxt) == len_q - 5'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // State and registered outputs
    always_ff @(posedge clk_3M or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= 5'd0;
            cnt_q     <= 5'd0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= 16'h0000;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            code_q    <= 2'b00;
            busy      <= 1'b0;
`ifdef MVB_WORD_CHECKSUM_EN
            acc_q     <= 16'h0000;
            chk_q     <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            code_q    <= code_d;
            busy      <= busy_d;
`ifdef MVB_WORD_CHECKSUM_EN
            acc_q     <= acc_d;
            chk_q     <= chk_d;
`endif
        end
    end

    // Frame buffer write; contents need no reset
    always_ff @(posedge clk_3M) begin
        if (wr_en) begin
            mem[cnt_q[AW-1:0]] <= word_in;
        end
    end

endmodule

// File: tb/tb_mvb_word_collector.sv
// Directed self-checking bench for mvb_word_collector.
// Inputs change 1 ns after the rising edge, outputs sampled there too.
module tb_mvb_word_collector;

    logic        clk_3M = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [4:0]  frame_len = 5'd0;
    logic [15:0] word_in = 16'h0000;
    logic        word_valid = 1'b0;
    logic        frame_end = 1'b0;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mvb_word_collector_if dn ();

    mvb_word_collector dut (
        .clk_3M      (clk_3M),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .frame_end   (frame_end),
        .dn          (dn.master),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 clk_3M = ~clk_3M;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_3M);
        #1;
    endtask

    task automatic start(input logic [4:0] l);
        frame_start = 1'b1;
        frame_len   = l;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic word(input logic [15:0] w);
        word_in    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    initial begin
        dn.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", dn.out_valid, 0);
        check("rst_data", dn.out_data, 16'h0000);
        check("rst_last", dn.out_last, 0);
        check("rst_ok", frame_ok, 0);
        check("rst_err", frame_err, 0);
        check("rst_code", err_code, 2'b00);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // 1: good len=4 frame, continuous drain
        dn.out_ready = 1'b1;
        start(5'd4);
        check("t1_busy", busy, 1);
        word(16'h1111);
        word(16'h2222);
        word(16'h3333);
        word(16'h4444);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'h4444);
`endif
        fend();
        check("t1_ok", frame_ok, 1);
        check("t1_err", frame_err, 0);
        check("t1_valid", dn.out_valid, 1);
        check("t1_d0", dn.out_data, 16'h1111);
        check("t1_l0", dn.out_last, 0);
        tick();
        check("t1_okpulse", frame_ok, 0);
        check("t1_d1", dn.out_data, 16'h2222);
        tick();
        check("t1_d2", dn.out_data, 16'h3333);
        check("t1_l2", dn.out_last, 0);
        tick();
        check("t1_d3", dn.out_data, 16'h4444);
        check("t1_l3", dn.out_last, 1);
        tick();
        check("t1_vdone", dn.out_valid, 0);
        check("t1_idle", busy, 0);

        // 2: short frame
        start(5'd4);
        word(16'hA001);
        word(16'hA002);
        word(16'hA003);
        fend();
        check("t2_err", frame_err, 1);
        check("t2_code", err_code, 2'b01);
        check("t2_ok", frame_ok, 0);
        check("t2_valid", dn.out_valid, 0);
        check("t2_busy", busy, 0);
        tick();
        check("t2_errpulse", frame_err, 0);
        check("t2_hold", err_code, 2'b01);
        check("t2_valid2", dn.out_valid, 0);

        // 3: long frame, last word with frame_end
        start(5'd2);
        word(16'hB001);
        word(16'hB002);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'hB003);
`endif
        word_in    = 16'hDEAD;
        word_valid = 1'b1;
        frame_end  = 1'b1;
        tick();
        word_valid = 1'b0;
        frame_end  = 1'b0;
        check("t3_err", frame_err, 1);
        check("t3_code", err_code, 2'b10);
        check("t3_busy", busy, 0);

        // 4: bad lengths
        start(5'd0);
        check("t4_err0", frame_err, 1);
        check("t4_code0", err_code, 2'b11);
        check("t4_busy0", busy, 0);
        tick();
        check("t4_gap", frame_err, 0);
        start(5'd17);
        check("t4_err17", frame_err, 1);
        check("t4_code17", err_code, 2'b11);
        check("t4_busy17", busy, 0);

        // 5: stalled drain, ready 1,0,0,1,1
        dn.out_ready = 1'b0;
        start(5'd3);
        word(16'h0A0A);
        word(16'h0B0B);
        word(16'h0C0C);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'h0D0D);
`endif
        fend();
        check("t5_ok", frame_ok, 1);
        check("t5_d0", dn.out_data, 16'h0A0A);
        dn.out_ready = 1'b1;
        tick();
        check("t5_d1", dn.out_data, 16'h0B0B);
        dn.out_ready = 1'b0;
        tick();
        check("t5_hold1", dn.out_data, 16'h0B0B);
        tick();
        check("t5_hold2", dn.out_data, 16'h0B0B);
        check("t5_holdv", dn.out_valid, 1);
        check("t5_holdl", dn.out_last, 0);
        dn.out_ready = 1'b1;
        tick();
        check("t5_d2", dn.out_data, 16'h0C0C);
        check("t5_l2", dn.out_last, 1);
        tick();
        check("t5_vdone", dn.out_valid, 0);
        check("t5_idle", busy, 0);

        // restart while collecting aborts with code 01
        start(5'd3);
        word(16'h1111);
        start(5'd2);
        check("ab_err", frame_err, 1);
        check("ab_code", err_code, 2'b01);
        check("ab_busy", busy, 1);
        word(16'h1234);
        word(16'h5678);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'h444C);
`endif
        fend();
        check("ab_ok", frame_ok, 1);
        check("ab_d0", dn.out_data, 16'h1234);
        tick();
        check("ab_d1", dn.out_data, 16'h5678);
        check("ab_l1", dn.out_last, 1);
        tick();
        check("ab_vdone", dn.out_valid, 0);

        // 6: async reset mid-collect
        start(5'd4);
        word(16'hC001);
        word(16'hC002);
        #2 rst = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_code", err_code, 2'b00);
        check("t6_valid", dn.out_valid, 0);
        check("t6_err", frame_err, 0);
        tick();
        check("t6_busy2", busy, 0);
        rst = 1'b1;
        tick();
        start(5'd1);
        word(16'h5A5A);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'h5A5A);
`endif
        fend();
        check("t6_ok", frame_ok, 1);
        check("t6_d0", dn.out_data, 16'h5A5A);
        check("t6_l0", dn.out_last, 1);
        tick();
        check("t6_vdone", dn.out_valid, 0);

        // len=1 with last word and end together; start during drain
        dn.out_ready = 1'b0;
        start(5'd1);
`ifdef MVB_WORD_CHECKSUM_EN
        word(16'h7E7E);
`endif
        word_in    = 16'h7E7E;
        word_valid = 1'b1;
        frame_end  = 1'b1;
        tick();
        word_valid = 1'b0;
        frame_end  = 1'b0;
        check("t7_ok", frame_ok, 1);
        check("t7_d0", dn.out_data, 16'h7E7E);
        check("t7_l0", dn.out_last, 1);
        start(5'd2);
        check("t7_err", frame_err, 1);
        check("t7_code", err_code, 2'b11);
        check("t7_valid", dn.out_valid, 1);
        check("t7_hold", dn.out_data, 16'h7E7E);
        check("t7_busy", busy, 1);
        dn.out_ready = 1'b1;
        tick();
        check("t7_vdone", dn.out_valid, 0);
        check("t7_idle", busy, 0);
        check("t7_nook", frame_ok, 0);

`ifdef MVB_WORD_CHECKSUM_EN
        // check word good, then bad
        start(5'd2);
        word(16'h00FF);
        word(16'h0F0F);
        word(16'h0FF0);
        fend();
        check("ck_ok", frame_ok, 1);
        check("ck_d0", dn.out_data, 16'h00FF);
        tick();
        check("ck_d1", dn.out_data, 16'h0F0F);
        check("ck_l1", dn.out_last, 1);
        tick();
        check("ck_vdone", dn.out_valid, 0);
        start(5'd2);
        word(16'h00FF);
        word(16'h0F0F);
        word(16'h0000);
        fend();
        check("ck_err", frame_err, 1);
        check("ck_code", err_code, 2'b11);
        check("ck_valid", dn.out_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
